// File: rtl/recolector_suma_pkg.sv
//------------------------------------------------------------------------------
// Module      : recolector_suma_pkg
// Description : Shared widths, entry field positions and sequence-checker
//               state encoding for the recolector_suma result collector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package recolector_suma_pkg;

  localparam int SUMW   = 4;
  localparam int IDXW   = 4;
  localparam int ENTRYW = 8;

  // Entry packing: {idx, sum}
  localparam int IDX_MSB = 7;
  localparam int IDX_LSB = 4;
  localparam int SUM_MSB = 3;
  localparam int SUM_LSB = 0;

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    TRACK = 1'b1
  } seq_state_t;

  function automatic logic [ENTRYW-1:0] pack_entry(input logic [IDXW-1:0] idx,
                                                   input logic [SUMW-1:0] sum);
    return {idx, sum};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sincrono.sv
//------------------------------------------------------------------------------
// Module      : fifo_sincrono
// Description : Synchronous show-ahead FIFO. The caller decides push/pop;
//               head data is forced to zero while empty so stale entries
//               never reach the output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_sincrono #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH == 2**AW.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/recolector_suma.sv
//------------------------------------------------------------------------------
// Module      : recolector_suma
// Description : Collects {idx, sum} results from the pipelined adder into a
//               show-ahead FIFO, checks tag ordering and accumulates sums.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module recolector_suma
  import recolector_suma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int ACCW  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [SUMW-1:0]   sum30_dd,
  input  logic [IDXW-1:0]   idx_dd,
  input  logic              valid_dd,
  input  logic              ready_out,
  output logic [ENTRYW-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              seq_err,
  output logic [ACCW-1:0]   acc
);

  logic       pop;
  logic       push;
  seq_state_t state;
  logic [IDXW-1:0] expected;

  // Pop only when an entry is actually presented; a pop frees the slot a
  // simultaneous push needs when full.
  assign valid_out = !empty;
  assign pop       = valid_out && ready_out;
  assign push      = valid_dd && (!full || pop);

  fifo_sincrono #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (ENTRYW)
  ) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push),
    .pop     (pop),
    .wr_data (pack_entry(idx_dd, sum30_dd)),
    .rd_data (data_out),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky overflow: a valid input that could not be pushed.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow <= 1'b0;
    end else if (valid_dd && !push) begin
      overflow <= 1'b1;
    end
  end

  // Running sum of accepted results; dropped inputs are excluded.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc <= '0;
    end else if (push) begin
      acc <= acc + ACCW'(sum30_dd);
    end
  end

  // Tag-sequence checker: sees every valid input, resynchronises on each one.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= FIRST;
      expected <= '0;
      seq_err  <= 1'b0;
    end else if (valid_dd) begin
      expected <= idx_dd + 1'b1;
      case (state)
        FIRST: begin
          state <= TRACK;
        end
        TRACK: begin
          if (idx_dd != expected) begin
            seq_err <= 1'b1;
          end
        end
        default: begin
          state <= FIRST;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/recolector_suma.md
Name: recolector_suma

Overview:
- Downstream stage of the pipelined 4-bit adder. Consumes the adder's registered result `sum30_dd` and its tag `idx_dd`.
- Buffers {idx, sum} pairs in a small synchronous FIFO and hands them out over a valid/ready handshake.
- Checks that the tags arrive in consecutive order and keeps a running accumulation of the accepted sums.
- Sits between the adder and the testbench checker, or any later consumer.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).
- ACCW, 8, accumulator width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- sum30_dd  in  4  adder result.
- idx_dd  in  4  adder tag for that result.
- valid_dd  in  1  result/tag pair is valid this cycle.
- ready_out  in  1  consumer accepts data_out this cycle.
- data_out  out  8  head entry, packed as {idx[3:0], sum[3:0]}.
- valid_out  out  1  head entry valid.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a valid input was dropped.
- seq_err  out  1  sticky: a tag was out of sequence.
- acc  out  ACCW  sum of all accepted sum30_dd values, mod 2^ACCW.

Behaviour:
- Reset (asynchronous, reset_L=0) clears everything, with effect immediately and independent of clk:
  - read/write pointers and count = 0; empty=1, full=0, valid_out=0.
  - data_out = 0, overflow = 0, seq_err = 0, acc = 0.
  - the sequence checker returns to its FIRST state.
- Reset asserted mid-operation discards all buffered entries. No output glitches to stale data after reset is released.
- FIFO is show-ahead:
  - valid_out = !empty.
  - data_out shows the head entry whenever valid_out=1, and 0 when empty.
- Pop: occurs when valid_out & ready_out. The read pointer advances on that clock edge.
- Push condition: valid_dd & (!full | pop).
  - The entry {idx_dd, sum30_dd} is written at the write pointer and the write pointer advances.
- Latency: an input pushed at edge N is visible on data_out after edge N when the FIFO was empty (1-cycle latency).
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- Boundary conditions:
  - Full, valid_dd=1, pop=1: push and pop both occur; count stays DEPTH; no overflow.
  - Full, valid_dd=1, no pop: input dropped; overflow set and held until reset.
  - Empty, ready_out=1: no pop; pointers unchanged.
  - Empty, valid_dd=1, ready_out=1: push only. The entry appears next cycle; there is no fall-through.
- Sequence checker FSM, evaluated on every valid_dd cycle, including dropped inputs:
  - FIRST: on valid_dd, expected <= idx_dd+1 (mod 16); go to TRACK. No check is made.
  - TRACK: on valid_dd:
    - if idx_dd != expected, set seq_err (sticky);
    - in all cases expected <= idx_dd+1 (mod 16), i.e. it resynchronises.
  - Tag wrap 15 -> 0 is legal.
- Accumulator:
  - on every push, acc <= acc + zero-extended sum30_dd, mod 2^ACCW;
  - dropped inputs are not accumulated.
- No combinational path from valid_dd to valid_out. ready_out affects only the push decision, via pop.

Decomposition:
- Shared include `recolector_defs.v` holds:
  - width constants: SUMW=4, IDXW=4, ENTRYW=8;
  - entry packing/field positions: idx [7:4], sum [3:0];
  - FSM state encodings: FIRST=0, TRACK=1.
- One sub-module is natural: `fifo_sincrono` (parameters DEPTH and width; push/pop/full/empty/count, show-ahead).
- The checker and accumulator stay in the top module.

Test Plan:
- Reset, then 3 pushes (idx 0,1,2; sums 3,5,7) with ready_out=0 -> count=3, data_out=8'h03, acc=15, seq_err=0, overflow=0.
- Fill to 4 entries, then push idx=4 with ready_out=0 -> full=1, count=4, overflow=1, acc unchanged by the dropped input, FIFO contents unchanged.
- Full, push and pop in the same cycle -> count stays 4, head advances, overflow unchanged, acc increases by the new sum.
- Tags 14,15,0,1 -> seq_err=0. Then tags 3,4 -> seq_err=1 after the tag-3 edge; tag 4 is accepted without a further error.
- Sums of 15 pushed 18 times with continuous pops -> acc = 270 mod 256 = 14; empty toggles correctly; no overflow.
- Assert reset_L mid-stream with 2 entries buffered -> immediately count=0, valid_out=0, data_out=0, acc=0, flags=0. The first post-reset tag (e.g. 9) produces no seq_err.
